// File: rtl/mmio_debug_port_pkg.sv
// Shared definitions for the memory-mapped debug port: base address,
// register offsets, register-select encoding and the STATUS word layout.
package mmio_debug_port_pkg;

  // Default byte address of register 0 (must stay 256-byte aligned)
  localparam logic [31:0] MMIO_DBG_BASE = 32'h8000_0100;

  // Register byte offsets from the base address
  localparam logic [7:0] DBG_PRINT_OFS    = 8'h00;
  localparam logic [7:0] DBG_DONE_OFS     = 8'h80;
  localparam logic [7:0] DBG_STATUS_OFS   = 8'h84;
  localparam logic [7:0] DBG_CYCLE_LO_OFS = 8'h88;
  localparam logic [7:0] DBG_CYCLE_HI_OFS = 8'h8C;

  // Which register an access targets once the base address has matched
  typedef enum logic [2:0] {
    REG_NONE,
    REG_PRINT,
    REG_DONE,
    REG_STATUS,
    REG_CYCLE_LO,
    REG_CYCLE_HI
  } dbg_reg_e;

  // STATUS register layout, MSB first
  typedef struct packed {
    logic [15:0] dropCount;
    logic [4:0]  reserved;
    logic        timeout;
    logic        doneReq;
    logic        overflow;
    logic [7:0]  fifoCount;
  } dbg_status_t;

  // Map a byte offset to a register; misaligned or unlisted offsets map to
  // REG_NONE so they read as zero and ignore writes.
  function automatic dbg_reg_e decodeOffset(input logic [7:0] ofs,
                                            input int         numChannels);
    dbg_reg_e sel;
    sel = REG_NONE;
    if (ofs[1:0] == 2'b00) begin
      if (ofs < DBG_DONE_OFS) begin
        if (int'(ofs[7:2]) < numChannels) begin
          sel = REG_PRINT;
        end
      end else begin
        case (ofs)
          DBG_DONE_OFS:     sel = REG_DONE;
          DBG_STATUS_OFS:   sel = REG_STATUS;
          DBG_CYCLE_LO_OFS: sel = REG_CYCLE_LO;
          DBG_CYCLE_HI_OFS: sel = REG_CYCLE_HI;
          default:          sel = REG_NONE;
        endcase
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mmio_debug_port_sync_fifo.sv
// Synchronous FIFO used to buffer print entries. A push while full is only
// accepted when a pop happens in the same cycle, so a full FIFO can stream.
// The head entry comes straight from storage, so there is no path from the
// push port to the head outputs within a cycle.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] headData_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              doPush;
  logic              doPop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign doPop      = pop_i && !empty_o;
  assign doPush     = push_i && (!full_o || doPop);
  assign headData_o = mem_q[rdPtr_q];
  assign count_o    = count_q;

  // Advance pointers and occupancy; DEPTH is a power of two so pointers wrap
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO without draining it
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

endmodule

// File: rtl/mmio_debug_port.sv
// Memory-mapped debug peripheral on the CPU data bus: print channels buffered
// into a FIFO and drained over a valid/ready stream, a sticky program-done
// flag with exit code, a 64-bit cycle counter with HI snapshot, a watchdog
// and a readable STATUS word.
module mmio_debug_port
  import mmio_debug_port_pkg::*;
#(
  parameter  logic [31:0] BASE_ADDR      = MMIO_DBG_BASE,
  parameter  int          NUM_CHANNELS   = 4,
  parameter  int          DEPTH          = 16,
  parameter  logic [63:0] TIMEOUT_CYCLES = 64'd0,
  localparam int          CH_W           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [31:0]     memory_address,
  input  logic            memory_write_enable,
  input  logic [31:0]     memory_write_data,
  input  logic            memory_read_enable,
  output logic [31:0]     memory_read_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_channel,
  output logic [31:0]     out_data,
  output logic            done,
  output logic [31:0]     exit_code,
  output logic            timeout
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int FIFO_W = CH_W + 32;

  dbg_reg_e          regSel;
  logic              addrHit;
  logic              pushReq;
  logic              fifoPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              dropEvent;
  logic [CNT_W-1:0]  fifoCount;
  logic [FIFO_W-1:0] fifoHead;
  logic [CH_W-1:0]   printChannel;
  dbg_status_t       statusWord;
  logic [31:0]       readMux;

  logic              overflow_q,    overflow_d;
  logic [15:0]       dropCount_q,   dropCount_d;
  logic              doneReq_q,     doneReq_d;
  logic [31:0]       exitCode_q,    exitCode_d;
  logic              timeout_q,     timeout_d;
  logic [63:0]       cycleCount_q,  cycleCount_d;
  logic [31:0]       cycleHiSnap_q, cycleHiSnap_d;
  logic [31:0]       readData_q,    readData_d;

  // Decode: the upper 24 address bits select this block, the low byte picks
  // the register; the print channel is the word index within the PRINT window
  assign addrHit      = (memory_address[31:8] == BASE_ADDR[31:8]);
  assign regSel       = addrHit ? decodeOffset(memory_address[7:0], NUM_CHANNELS) : REG_NONE;
  assign printChannel = memory_address[CH_W+1:2];

  // Prints are frozen once the program has signalled done, and those ignored
  // writes are not drops
  assign pushReq   = memory_write_enable && (regSel == REG_PRINT) && !doneReq_q;
  assign fifoPop   = !fifoEmpty && out_ready;
  assign dropEvent = pushReq && fifoFull && !fifoPop;

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) fifo_u (
    .clk        (clk),
    .n_rst      (n_rst),
    .push_i     (pushReq),
    .pushData_i ({printChannel, memory_write_data}),
    .pop_i      (fifoPop),
    .headData_o (fifoHead),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount)
  );

  // Assemble the STATUS word from the current (pre-edge) state
  always_comb begin
    statusWord           = '0;
    statusWord.fifoCount = 8'(fifoCount);
    statusWord.overflow  = overflow_q;
    statusWord.doneReq   = doneReq_q;
    statusWord.timeout   = timeout_q;
    statusWord.dropCount = dropCount_q;
  end

  // Select the value a load returns; PRINT, DONE and unlisted offsets read 0
  always_comb begin
    readMux = 32'd0;
    case (regSel)
      REG_STATUS:   readMux = statusWord;
      REG_CYCLE_LO: readMux = cycleCount_q[31:0];
      REG_CYCLE_HI: readMux = cycleHiSnap_q;
      default:      readMux = 32'd0;
    endcase
  end

  // Next state for flags, counters, the watchdog and the registered read port
  always_comb begin
    overflow_d    = overflow_q;
    dropCount_d   = dropCount_q;
    doneReq_d     = doneReq_q;
    exitCode_d    = exitCode_q;
    timeout_d     = timeout_q;
    cycleCount_d  = cycleCount_q + 64'd1;
    cycleHiSnap_d = cycleHiSnap_q;
    readData_d    = readData_q;

    if (dropEvent) begin
      overflow_d = 1'b1;
      if (dropCount_q != 16'hFFFF) begin
        dropCount_d = dropCount_q + 16'd1;
      end
    end

    if (memory_write_enable && (regSel == REG_DONE) && !doneReq_q) begin
      doneReq_d  = 1'b1;
      exitCode_d = memory_write_data;
    end

    if ((TIMEOUT_CYCLES != 64'd0) && (cycleCount_q == TIMEOUT_CYCLES) && !doneReq_q) begin
      timeout_d = 1'b1;
    end

    if (memory_read_enable) begin
      readData_d = readMux;
      if (regSel == REG_CYCLE_LO) begin
        cycleHiSnap_d = cycleCount_q[63:32];
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      overflow_q    <= 1'b0;
      dropCount_q   <= 16'd0;
      doneReq_q     <= 1'b0;
      exitCode_q    <= 32'd0;
      timeout_q     <= 1'b0;
      cycleCount_q  <= 64'd0;
      cycleHiSnap_q <= 32'd0;
      readData_q    <= 32'd0;
    end else begin
      overflow_q    <= overflow_d;
      dropCount_q   <= dropCount_d;
      doneReq_q     <= doneReq_d;
      exitCode_q    <= exitCode_d;
      timeout_q     <= timeout_d;
      cycleCount_q  <= cycleCount_d;
      cycleHiSnap_q <= cycleHiSnap_d;
      readData_q    <= readData_d;
    end
  end

  assign memory_read_data = readData_q;
  assign out_valid        = !fifoEmpty;
  assign out_channel      = fifoHead[FIFO_W-1:32];
  assign out_data         = fifoHead[31:0];
  assign done             = doneReq_q && fifoEmpty;
  assign exit_code        = exitCode_q;
  assign timeout          = timeout_q;

endmodule
